// File: rtl/tpu_pkg.sv
// Shared Mini TPU definitions: datapath widths, opcode encodings, FSM state types.
package tpu_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int INSTR_WIDTH = 16;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [INSTR_WIDTH-1:0] INSTR_RESET = 16'h4000;

  typedef enum logic {LO_WAIT, HI_HELD} asm_state_t;
  typedef enum logic {IDLE, COMPUTE} iss_state_t;

  function automatic logic [1:0] opcode(input logic [INSTR_WIDTH-1:0] w);
    return w[INSTR_WIDTH-1 -: 2];
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO: wrap-around pointers plus an explicit occupancy count.
module instr_fifo
  import tpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [INSTR_WIDTH-1:0] din,
  input  logic                   pop,
  output logic [INSTR_WIDTH-1:0] dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_count;
  logic                   w_do_push;
  logic                   w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: pairs input bytes into 16-bit words, buffers them, and issues
// one per cycle except while a START-triggered compute window is running.
module instr_fetch
  import tpu_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int COMPUTE_CYCLES = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic [INSTR_WIDTH-1:0]      instruction,
  output logic                        instr_valid,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam logic [7:0] CNT_LOAD = 8'(COMPUTE_CYCLES - 1);

  asm_state_t             r_asm_state;
  logic [DATA_WIDTH-1:0]  r_high;
  iss_state_t             r_iss_state;
  logic [7:0]             r_cnt;

  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_start;
  logic                   w_full;
  logic                   w_empty;
  logic [INSTR_WIDTH-1:0] w_head;

  assign byte_ready = !w_full;
  assign w_accept   = byte_valid && byte_ready;
  assign w_push     = w_accept && (r_asm_state == HI_HELD);
  // The edge that closes the compute window is also allowed to issue, so the
  // next instruction lands exactly COMPUTE_CYCLES edges after the START.
  assign w_pop      = !w_empty &&
                      ((r_iss_state == IDLE) || (r_cnt == '0));
  assign w_start    = w_pop && (opcode(w_head) == OP_START);

  instr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   ({r_high, byte_in}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm_state <= LO_WAIT;
      r_high      <= '0;
    end else if (w_accept) begin
      if (r_asm_state == LO_WAIT) begin
        r_high      <= byte_in;
        r_asm_state <= HI_HELD;
      end else begin
        r_asm_state <= LO_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_state <= IDLE;
      r_cnt       <= '0;
      instruction <= INSTR_RESET;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      instr_valid <= w_pop;
      if (w_pop) instruction <= w_head;
      if (w_start) begin
        r_cnt       <= CNT_LOAD;
        r_iss_state <= COMPUTE;
        busy        <= 1'b1;
      end else if (r_iss_state == COMPUTE) begin
        if (r_cnt == '0) begin
          r_iss_state <= IDLE;
          busy        <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed sequences plus random byte traffic, checked
// against a queue-based model of pairing, buffering and issue pacing.
module tb_instr_fetch;
  localparam int DEPTH = 4;
  localparam int CC    = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q[$];
  bit          held;
  logic [7:0]  hi;
  int          edge_n;
  int          next_allowed;
  logic [15:0] m_instr;
  bit          m_valid;
  bit          m_busy;
  bit          m_acc;

  instr_fetch #(
    .FIFO_DEPTH     (DEPTH),
    .COMPUTE_CYCLES (CC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held         = 0;
    hi           = '0;
    edge_n       = 0;
    next_allowed = 0;
    m_instr      = 16'h4000;
    m_valid      = 0;
    m_busy       = 0;
    m_acc        = 0;
  endtask

  // One rising edge of the reference: issue decision on the pre-edge queue, then byte intake.
  task automatic model_edge(input bit v, input logic [7:0] b);
    bit pop;
    logic [15:0] w;
    m_acc = v && (q.size() != DEPTH);
    pop   = (q.size() > 0) && (edge_n >= next_allowed);
    m_valid = pop;
    if (pop) begin
      w = q.pop_front();
      m_instr = w;
      if (w[15:14] == 2'b00) next_allowed = edge_n + CC;
    end
    if (m_acc) begin
      if (held) begin
        q.push_back({hi, b});
        held = 0;
      end else begin
        hi   = b;
        held = 1;
      end
    end
    m_busy = edge_n < next_allowed;
    edge_n++;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit v, input logic [7:0] b);
    byte_valid = v;
    byte_in    = b;
    #1;
    chk("byte_ready", {31'b0, byte_ready}, {31'b0, q.size() != DEPTH});
    @(posedge clk);
    model_edge(v, b);
    #1;
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("instruction", {16'b0, instruction}, {16'b0, m_instr});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("fifo_count", {29'b0, fifo_count}, q.size());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int tries = 0;
    do begin
      step(1, b);
      tries++;
    end while (!m_acc && tries < 200);
    if (!m_acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    byte_valid = 0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    byte_valid = 0;
    #2;
    chk("rst_instruction", {16'b0, instruction}, 32'h4000);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_fifo_count", {29'b0, fifo_count}, 32'd0);
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] w;
    model_reset();
    @(negedge clk);
    do_reset();

    send_word(16'h812A);
    idle(4);

    send_word(16'h8001);
    send_word(16'hA502);
    send_word(16'h8F03);
    idle(4);

    send_word(16'h0000);
    send_word(16'hC500);
    idle(14);

    send_word(16'h0000);
    send_word(16'h8111);
    send_word(16'h9222);
    send_word(16'hA333);
    send_word(16'hB444);
    send_word(16'hC555);
    idle(14);

    send_byte(8'hA0);
    idle(1);
    do_reset();
    send_word(16'h8111);
    idle(4);

    for (int i = 0; i < 12; i++) begin
      w = {1'b1, i[0], 6'(i), 8'(i * 17)};
      send_word(w);
    end
    idle(4);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), 8'($urandom));
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
